// File: rtl/text_buffer_ctrl.sv
// Character-cell text buffer: consumes ASCII bytes, keeps an 80x30 grid with
// cursor handling and circular-offset scrolling, and serves a registered read port.
module text_buffer_ctrl #(
  parameter int COLS  = 80,
  parameter int ROWS  = 30,
  parameter int COL_W = 7,
  parameter int ROW_W = 5
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_ascii,
  output logic             in_ready,
  input  logic [ROW_W-1:0] rd_row,
  input  logic [COL_W-1:0] rd_col,
  output logic [7:0]       rd_char,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  localparam int DEPTH  = ROWS * COLS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_FILL = ADDR_W'(COLS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W:0]    ROWS_X    = (ROW_W+1)'(ROWS);
  localparam logic [7:0]        SPACE     = 8'h20;

  typedef enum logic [1:0] {CLR_ALL = 2'd0, IDLE = 2'd1, CLR_LINE = 2'd2} state_t;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // the source holds in_ascii stable until then, and in_ready is only high in IDLE.
  state_t            state;
  logic [ADDR_W-1:0] fill;
  logic [ADDR_W-1:0] clr_base;
  logic [ROW_W-1:0]  top;
  logic [7:0]        mem [DEPTH];

  function automatic logic [ROW_W-1:0] wrap_row(input logic [ROW_W-1:0] r,
                                                input logic [ROW_W-1:0] t);
    logic [ROW_W:0] s;
    s = {1'b0, r} + {1'b0, t};
    if (s >= ROWS_X) s = s - ROWS_X;
    return s[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  logic              accept, printable, is_bs, newline;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;

  assign fsm_state = state;
  assign accept    = in_valid && in_ready;
  assign printable = (in_ascii >= 8'h20) && (in_ascii <= 8'h7E);
  assign is_bs     = (in_ascii == 8'h08);
  assign newline   = accept && ((printable && cursor_col == LAST_COL) || in_ascii == 8'h0A);

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = SPACE;
    case (state)
      CLR_ALL: begin
        we    = 1'b1;
        waddr = fill;
      end
      CLR_LINE: begin
        we    = 1'b1;
        waddr = clr_base + fill;
      end
      IDLE: begin
        if (accept && printable) begin
          we    = 1'b1;
          waddr = cell_addr(wrap_row(cursor_row, top), cursor_col);
          wdata = in_ascii;
        end else if (accept && is_bs && cursor_col != '0) begin
          we    = 1'b1;
          waddr = cell_addr(wrap_row(cursor_row, top), cursor_col - COL_W'(1));
        end else if (accept && is_bs && cursor_row != '0) begin
          we    = 1'b1;
          waddr = cell_addr(wrap_row(cursor_row - ROW_W'(1), top), LAST_COL);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state      <= CLR_ALL;
      fill       <= '0;
      clr_base   <= '0;
      top        <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b1;
    end else begin
      case (state)
        CLR_ALL: begin
          if (fill == LAST_ADDR) begin
            state    <= IDLE;
            fill     <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            fill <= fill + ADDR_W'(1);
          end
        end
        CLR_LINE: begin
          if (fill == LAST_FILL) begin
            state    <= IDLE;
            fill     <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            fill <= fill + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (accept && in_ascii == 8'h0C) begin
            state      <= CLR_ALL;
            fill       <= '0;
            top        <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
          end else if (accept) begin
            if (printable) begin
              cursor_col <= (cursor_col == LAST_COL) ? '0 : cursor_col + COL_W'(1);
            end else if (in_ascii == 8'h0A || in_ascii == 8'h0D) begin
              cursor_col <= '0;
            end else if (is_bs && cursor_col != '0) begin
              cursor_col <= cursor_col - COL_W'(1);
            end else if (is_bs && cursor_row != '0) begin
              cursor_row <= cursor_row - ROW_W'(1);
              cursor_col <= LAST_COL;
            end
            // Scrolling: the old top physical row becomes the new bottom line.
            if (newline && cursor_row != LAST_ROW) begin
              cursor_row <= cursor_row + ROW_W'(1);
            end else if (newline) begin
              top      <= (top == LAST_ROW) ? '0 : top + ROW_W'(1);
              clr_base <= cell_addr(top, '0);
              state    <= CLR_LINE;
              fill     <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        default: state <= CLR_ALL;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      rd_char <= SPACE;
    end else if (rd_row <= LAST_ROW && rd_col <= LAST_COL) begin
      rd_char <= mem[cell_addr(wrap_row(rd_row, top), rd_col)];
    end else begin
      rd_char <= SPACE;
    end
  end

endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
Character-cell text buffer for the terminal display path. It accepts ASCII bytes from the input/UART side and maintains an 80x30 character grid. It handles cursor advance, wrap, CR/LF, backspace, form-feed clear, and hardware scroll through a circular top-line offset. A registered read port supplies character codes to the pixel stage (pixels_ctrl) for glyph lookup.

Parameters:
COLS, 80, text columns per line
ROWS, 30, text lines
COL_W, 7, width of column indices (ceil log2 COLS)
ROW_W, 5, width of row indices (ceil log2 ROWS)

Ports:
Clk  input  1  system/pixel-domain clock
rst  input  1  asynchronous, active-low reset
in_valid  input  1  in_ascii holds a byte to consume
in_ascii  input  8  character byte
in_ready  output  1  block can accept a byte this cycle
rd_row  input  ROW_W  logical text row requested by the pixel stage (0 = top of screen)
rd_col  input  COL_W  text column requested by the pixel stage
rd_char  output  8  character at (rd_row, rd_col); 1-cycle latency
cursor_row  output  ROW_W  logical cursor row
cursor_col  output  COL_W  cursor column
busy  output  1  a clear or scroll fill is in progress

Behaviour:
- Storage: dual-port RAM of ROWS*COLS bytes. Physical row = (logical row + top) mod ROWS. Address = phys_row*COLS + col (12 bits at defaults).
- Reset (rst low, asynchronous): state=CLR_ALL, fill counter=0, top=0, cursor=(0,0), in_ready=0, busy=1, rd_char=0x20. RAM contents are not reset directly; CLR_ALL overwrites them.
- FSM states: CLR_ALL, IDLE, CLR_LINE.
  - CLR_ALL: writes 0x20 to one address per cycle, 0 .. ROWS*COLS-1 (2400 cycles). Then goes to IDLE, with busy=0 and in_ready=1.
  - IDLE: in_ready=1. A byte is accepted on the rising edge where in_valid && in_ready. Any RAM write and cursor/top update happen on that same edge.
  - CLR_LINE: writes 0x20 to cols 0..COLS-1 of the physical row being cleared, one per cycle (COLS cycles). Then goes to IDLE.
- Accepted byte handling:
  - 0x20..0x7E: write byte at cursor, then advance col. If col was COLS-1: col=0 and do NEWLINE.
  - 0x0A (LF): col=0, then NEWLINE.
  - 0x0D (CR): col=0. No write.
  - 0x08 (BS):
    - col>0: col-1, write 0x20 at the new position.
    - col==0 and row>0: row-1, col=COLS-1, write 0x20 there.
    - (0,0): no-op.
  - 0x0C (FF): top=0, cursor=(0,0), go to CLR_ALL.
  - Any other byte is accepted and ignored; no state change.
- NEWLINE:
  - If row<ROWS-1: row+1, stay in IDLE.
  - Else (scroll): top=(top+1) mod ROWS, row stays ROWS-1. Go to CLR_LINE targeting the new bottom physical row, which equals the old top.
- Throughput: one byte per cycle in IDLE when no scroll or clear is triggered. A scrolling byte leaves in_ready low for exactly COLS cycles. FF leaves it low for ROWS*COLS cycles.
- Read port:
  - rd_char is registered from (rd_row, rd_col) using the current top, so latency is 1 cycle.
  - Out-of-range rd_row>=ROWS or rd_col>=COLS returns 0x20.
  - The read port runs every cycle, independent of FSM state. During CLR_LINE/CLR_ALL the displayed bottom line may show stale bytes until it is overwritten; this is accepted.
- Wrap arithmetic: top and physical row are computed mod ROWS by compare-and-subtract; no multiplier beyond the constant COLS scaling.
- in_valid while in_ready=0: the byte is not consumed. The source must hold it.
- Reset asserted mid-fill or mid-scroll: immediate return to reset values, and CLR_ALL restarts from address 0.

Test Plan:
- Reset release -> busy=1 and in_ready=0 for 2400 cycles. Then in_ready=1, and every rd_char read (e.g. (0,0), (29,79)) returns 0x20 one cycle after address.
- Send "AB" back-to-back -> cursor=(0,2), rd (0,0)=0x41, rd (0,1)=0x42. in_ready never drops.
- Send 80 x 'x' -> after the 80th byte, cursor=(1,0) and rd (0,79)=0x78. Then BS -> cursor=(0,79) and rd (0,79)=0x20. BS at (0,0) -> no change.
- Fill to row 29 with LFs, write 'Z' at (29,0), then LF -> in_ready low exactly 80 cycles. Afterward rd (28,0)=0x5A, row 29 reads all 0x20, and cursor=(29,0).
- Send 0x0C after text -> cursor=(0,0), busy high 2400 cycles, and all cells read 0x20. Also: a byte held on in_valid during busy is accepted only on the first cycle in_ready=1.
- Assert rst low in the middle of the CLR_LINE fill -> outputs return to reset values immediately, and the full 2400-cycle clear reruns.
